// File: rtl/fluid_board_soc_nios2_qsys_0_cpu_debug_pkg.sv
// Shared definitions for the debug-RAM arbiter: FSM encoding, jdo field
// positions and the default RAM word-address width.
package fluid_board_soc_nios2_qsys_0_cpu_debug_pkg;

    localparam int DEF_RAM_AW    = 8;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_RD,
        ST_J_CAP,
        ST_A_RD,
        ST_A_CAP
    } dbg_state_e;

endpackage

// File: rtl/fluid_board_soc_nios2_qsys_0_cpu_debug_mem_rr2.sv
// Two-requester round-robin grant (JTAG vs Avalon). The priority pointer only
// moves on a contested cycle, so an uncontested grant never costs the other side.
module fluid_board_soc_nios2_qsys_0_cpu_debug_mem_rr2 (
    input  logic clk,
    input  logic reset_n,
    input  logic req_jtag_i,
    input  logic req_avs_i,
    output logic gnt_jtag_o,
    output logic gnt_avs_o
);

    logic prio_avs_q;
    logic prio_avs_d;
    logic contest;

    assign contest    = req_jtag_i & req_avs_i;
    assign gnt_jtag_o = req_jtag_i & ~(contest & prio_avs_q);
    assign gnt_avs_o  = req_avs_i & ~(contest & ~prio_avs_q);
    assign prio_avs_d = contest ? ~prio_avs_q : prio_avs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_avs_q <= 1'b0;
        end else begin
            prio_avs_q <= prio_avs_d;
        end
    end

endmodule

// File: rtl/fluid_board_soc_nios2_qsys_0_cpu_debug_mem_arb.sv
// Debug-RAM port arbiter between the JTAG debug path and the CPU Avalon slave.
// Define FLUID_BOARD_SOC_DEBUG_MEM_AUTOINC_EN to post-increment MonAReg after each JTAG access.
module fluid_board_soc_nios2_qsys_0_cpu_debug_mem_arb
    import fluid_board_soc_nios2_qsys_0_cpu_debug_pkg::*;
#(
    parameter int RAM_AW = DEF_RAM_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [RAM_AW-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    dbg_state_e        state_q;
    logic [RAM_AW-1:0] mon_areg_q;
    logic [31:0]       mon_dreg_q;
    logic [31:0]       avs_rdata_q;
    logic [RAM_AW-1:0] rd_addr_q;
    logic              ram_rd_q;
    logic              pend_q;
    logic              pend_wr_q;
    logic [31:0]       pend_wdata_q;
    logic              overrun_q;

    logic              idle;
    logic              jpulse;
    logic              busy;
    logic              jaccept;
    logic              jdrop;
    logic              jreq;
    logic              areq;
    logic              jwr;
    logic [31:0]       jwdata;
    logic              gnt_j;
    logic              gnt_a;
    logic              jdo_unused;

    assign jdo_unused = ^{jdo[JDO_W-1:JDO_WDATA_LSB+JDO_WDATA_W], jdo[JDO_WDATA_LSB-1:0]};

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign idle    = (state_q == ST_IDLE) & reset_n;
    assign jpulse  = take_no_action_ocimem_a | take_action_ocimem_b;
    assign busy    = pend_q | (state_q == ST_J_RD) | (state_q == ST_J_CAP);
    assign jaccept = jpulse & ~busy;
    assign jdrop   = jpulse & busy;
    assign jreq    = idle & (pend_q | jaccept);
    assign areq    = idle & (avs_read | avs_write);
    assign jwr     = pend_q ? pend_wr_q : take_action_ocimem_b;
    assign jwdata  = pend_q ? pend_wdata_q : jdo[JDO_WDATA_LSB +: JDO_WDATA_W];

    fluid_board_soc_nios2_qsys_0_cpu_debug_mem_rr2 u_rr2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_jtag_i (jreq),
        .req_avs_i  (areq),
        .gnt_jtag_o (gnt_j),
        .gnt_avs_o  (gnt_a)
    );

    // Writes complete combinationally in the grant cycle; reads use the latched address.
    assign ram_wr    = (gnt_j & jwr) | (gnt_a & avs_write);
    assign ram_addr  = gnt_j ? mon_areg_q : (gnt_a ? avs_address : rd_addr_q);
    assign ram_wdata = gnt_j ? jwdata : avs_writedata;
    assign ram_be    = gnt_j ? 4'hF : avs_byteenable;
    assign ram_rd    = ram_rd_q;

    assign avs_waitrequest = reset_n & (avs_read | avs_write)
                           & ~(gnt_a & avs_write) & ~(state_q == ST_A_CAP);
    assign avs_readdata    = (state_q == ST_A_CAP) ? ram_rdata : avs_rdata_q;

    assign MonDReg      = mon_dreg_q;
    assign jtag_busy    = busy;
    assign jtag_overrun = overrun_q;

`ifdef FLUID_BOARD_SOC_DEBUG_MEM_AUTOINC_EN
    logic jdone;
    assign jdone = (gnt_j & jwr) | (state_q == ST_J_CAP);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mon_areg_q   <= '0;
            mon_dreg_q   <= '0;
            avs_rdata_q  <= '0;
            rd_addr_q    <= '0;
            ram_rd_q     <= 1'b0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_wdata_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            ram_rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_j && !jwr) begin
                        state_q   <= ST_J_RD;
                        ram_rd_q  <= 1'b1;
                        rd_addr_q <= mon_areg_q;
                    end else if (gnt_a && !avs_write) begin
                        state_q   <= ST_A_RD;
                        ram_rd_q  <= 1'b1;
                        rd_addr_q <= avs_address;
                    end
                end
                ST_J_RD:  state_q <= ST_J_CAP;
                ST_J_CAP: begin
                    mon_dreg_q <= ram_rdata;
                    state_q    <= ST_IDLE;
                end
                ST_A_RD:  state_q <= ST_A_CAP;
                ST_A_CAP: begin
                    avs_rdata_q <= ram_rdata;
                    state_q     <= ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase

            // A pulse that cannot be served this cycle waits in the pending flop.
            if (jaccept && !gnt_j) begin
                pend_q       <= 1'b1;
                pend_wr_q    <= take_action_ocimem_b;
                pend_wdata_q <= jdo[JDO_WDATA_LSB +: JDO_WDATA_W];
            end else if (gnt_j) begin
                pend_q <= 1'b0;
            end

            if (jdrop) begin
                overrun_q <= 1'b1;
            end else if (take_action_ocimem_a) begin
                overrun_q <= 1'b0;
            end

            if (take_action_ocimem_a) begin
                mon_areg_q <= jdo[JDO_ADDR_LSB +: RAM_AW];
`ifdef FLUID_BOARD_SOC_DEBUG_MEM_AUTOINC_EN
            end else if (jdone) begin
                mon_areg_q <= mon_areg_q + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fluid_board_soc_nios2_qsys_0_cpu_debug_mem_arb.sv
// Scoreboard bench: expected RAM accesses and Avalon read data are queued by the
// stimulus and checked in order by a negedge monitor.
module tb_fluid_board_soc_nios2_qsys_0_cpu_debug_mem_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_rd;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] ard_q[$];
    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;

    fluid_board_soc_nios2_qsys_0_cpu_debug_mem_arb #(.RAM_AW(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_rd                  (ram_rd),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after ram_rd.
    initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    always @(posedge clk) begin
        if (ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic acc_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d; e.be = be;
        return e;
    endfunction

    // Monitor: every RAM access and every completed Avalon read is checked in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_wr || ram_rd) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: got wr=%0b rd=%0b addr=%h want none",
                             ram_wr, ram_rd, ram_addr);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("acc_kind", {31'd0, ram_wr}, {31'd0, e.wr});
                    chk("acc_addr", {24'd0, ram_addr}, {24'd0, e.addr});
                    if (e.wr) begin
                        chk("acc_wdata", ram_wdata, e.data);
                        chk("acc_be", {28'd0, ram_be}, {28'd0, e.be});
                    end
                end
            end
            if (avs_read && !avs_waitrequest) begin
                if (ard_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_readdata: got %h want none", avs_readdata);
                end else begin
                    chk("avs_readdata", avs_readdata, ard_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic jtag_addr(input logic [7:0] a);
        jdo = '0;
        jdo[24:17] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_wr(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_rd();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Avalon transfer, optionally with a coincident JTAG read pulse; cyc = request cycles.
    task automatic avs_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic jpulse, output int cyc);
        logic done;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        avs_write = wr; avs_read = ~wr;
        take_no_action_ocimem_a = jpulse;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            done = ~avs_waitrequest;
            tick();
            take_no_action_ocimem_a = 1'b0;
        end
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    initial begin
        int cyc;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_flags", {28'd0, ram_rd, ram_wr, jtag_busy, jtag_overrun}, 32'h0);
        chk("rst_waitreq", {31'd0, avs_waitrequest}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // JTAG write then read back through MonDReg
        jtag_addr(8'h10);
        acc_q.push_back(mk(1'b1, 8'h10, 32'hDEADBEEF, 4'hF));
        jtag_wr(32'hDEADBEEF);
        jtag_addr(8'h10);
        acc_q.push_back(mk(1'b0, 8'h10, 32'h0, 4'h0));
        jtag_rd();
        tick();
        chk("jrd_busy", {31'd0, jtag_busy}, 32'h1);
        chk("jrd_mon_early", MonDReg, 32'h0);
        tick();
        chk("jrd_mon", MonDReg, 32'hDEADBEEF);
        chk("jrd_idle", {31'd0, jtag_busy}, 32'h0);

        // Uncontested Avalon read and partial write
        acc_q.push_back(mk(1'b0, 8'h05, 32'h0, 4'h0));
        ard_q.push_back(32'hA5A50005);
        avs_xfer(1'b0, 8'h05, 32'h0, 4'h0, 1'b0, cyc);
        chk("ard_cycles", cyc, 3);
        acc_q.push_back(mk(1'b1, 8'h22, 32'h12345678, 4'b0101));
        avs_xfer(1'b1, 8'h22, 32'h12345678, 4'b0101, 1'b0, cyc);
        chk("awr_cycles", cyc, 1);
        acc_q.push_back(mk(1'b0, 8'h22, 32'h0, 4'h0));
        ard_q.push_back(32'hA5340078);
        avs_xfer(1'b0, 8'h22, 32'h0, 4'h0, 1'b0, cyc);
        chk("ard2_cycles", cyc, 3);

        // Contention round 1: JTAG wins after reset
        jtag_addr(8'h30);
        acc_q.push_back(mk(1'b0, 8'h30, 32'h0, 4'h0));
        acc_q.push_back(mk(1'b1, 8'h40, 32'h11112222, 4'hF));
        avs_xfer(1'b1, 8'h40, 32'h11112222, 4'hF, 1'b1, cyc);
        chk("rr1_cycles", cyc, 4);
        chk("rr1_mon", MonDReg, 32'hA5A50030);

        // Contention round 2: Avalon wins, JTAG read waits in the pending flop
        jtag_addr(8'h31);
        acc_q.push_back(mk(1'b1, 8'h41, 32'h33334444, 4'hF));
        acc_q.push_back(mk(1'b0, 8'h31, 32'h0, 4'h0));
        avs_xfer(1'b1, 8'h41, 32'h33334444, 4'hF, 1'b1, cyc);
        chk("rr2_cycles", cyc, 1);
        chk("rr2_pending", {31'd0, jtag_busy}, 32'h1);
        repeat (3) tick();
        chk("rr2_mon", MonDReg, 32'hA5A50031);

        // Address wrap at all-ones
        jtag_addr(8'hFF);
        acc_q.push_back(mk(1'b1, 8'hFF, 32'hCAFE0001, 4'hF));
        jtag_wr(32'hCAFE0001);
`ifdef FLUID_BOARD_SOC_DEBUG_MEM_AUTOINC_EN
        acc_q.push_back(mk(1'b1, 8'h00, 32'hCAFE0002, 4'hF));
`else
        acc_q.push_back(mk(1'b1, 8'hFF, 32'hCAFE0002, 4'hF));
`endif
        jtag_wr(32'hCAFE0002);
        tick();

        // Overrun: second pulse during J_RD is dropped
        jtag_addr(8'h50);
        acc_q.push_back(mk(1'b0, 8'h50, 32'h0, 4'h0));
        jtag_rd();
        jtag_wr(32'h99999999);
        chk("ovr_set", {31'd0, jtag_overrun}, 32'h1);
        repeat (2) tick();
        chk("ovr_sticky", {31'd0, jtag_overrun}, 32'h1);
        chk("ovr_mon", MonDReg, 32'hA5A50050);
        jtag_addr(8'h60);
        chk("ovr_clear", {31'd0, jtag_overrun}, 32'h0);

        // Reset during A_RD aborts the access
        avs_address = 8'h07; avs_read = 1'b1;
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_waitreq", {31'd0, avs_waitrequest}, 32'h0);
        chk("mid_flags", {29'd0, ram_rd, ram_wr, jtag_busy}, 32'h0);
        chk("mid_regs", MonDReg | avs_readdata, 32'h0);
        avs_read = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        acc_q.push_back(mk(1'b0, 8'h07, 32'h0, 4'h0));
        ard_q.push_back(32'hA5A50007);
        avs_xfer(1'b0, 8'h07, 32'h0, 4'h0, 1'b0, cyc);
        chk("post_rst_cycles", cyc, 3);

        repeat (3) tick();
        chk("acc_q_empty", acc_q.size(), 0);
        chk("ard_q_empty", ard_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
